mult_scheduler: RTL and testbench
=================================

// Module: mult_scheduler
// PURPOSE
//   Shares one 8-bit signed add-shift multiplier datapath between NUM_REQ requesters.
//   Round-robin arbitration. Latches the winner's operands, then drives the datapath
//   controls (clr_ld, clearA, add, sub, shift, reset_au, S) for a fixed-latency
//   multiply. Returns the 16-bit product on a valid/ready response channel.
//   Replaces switch-driven sequencing when the multiplier serves on-chip clients.
// PARAMETERS
//   NUM_REQ  2  number of requesters (2..4)
//   WIDTH    8  operand width; must match the datapath (fixed 8 in this revision)
// PORTS
//   clk           in   1                clock, all state on rising edge
//   reset         in   1                asynchronous, active-low reset
//   req_valid     in   NUM_REQ          requester i has an operation pending
//   req_ready     out  NUM_REQ          one-hot: requester i accepted this cycle
//   req_mcand     in   NUM_REQ x WIDTH  multiplicand (signed), per requester
//   req_mplier    in   NUM_REQ x WIDTH  multiplier (signed), per requester
//   resp_valid    out  1                product available
//   resp_ready    in   1                consumer takes the product
//   resp_id       out  $clog2(NUM_REQ)  index of the requester owning the product
//   resp_product  out  2*WIDTH          signed product {Aval,Bval}
//   dp_S          out  WIDTH            operand bus into the datapath
//   dp_clr_ld     out  1                clear A, load B from dp_S
//   dp_clearA     out  1                clear A and x only
//   dp_add        out  1                A,x <- A + dp_S (sign-extended)
//   dp_sub        out  1                A,x <- A - dp_S
//   dp_shift      out  1                arithmetic right shift of {x,A,B}
//   dp_reset_au   out  1                synchronous datapath clear
//   dp_m          in   1                current LSB of B
//   dp_Aval       in   WIDTH            datapath A register
//   dp_Bval       in   WIDTH            datapath B register
// BEHAVIOUR
//   - reset low: state CLR; rr pointer=0; all outputs 0; count=0; product register=0.
//   - CLR: dp_reset_au=1 for exactly one cycle -> IDLE.
//   - IDLE: req_ready = arbiter grant (one-hot, only if any req_valid). Arbiter picks the
//     first valid index at or after the pointer. On accept, latch mcand, mplier and id.
//     Pointer <- winner+1 mod NUM_REQ. -> LOAD. With no valid requests: no ready, pointer held.
//   - LOAD: dp_S=mplier, dp_clr_ld=1; count<=0 -> ADD.
//   - ADD: dp_S=mcand. Sample dp_m: m=1 and count<WIDTH-1 -> dp_add=1; m=1 and
//     count==WIDTH-1 -> dp_sub=1; m=0 -> no op (cycle still spent). -> SHIFT.
//   - SHIFT: dp_shift=1, count<=count+1. count+1==WIDTH -> CAPT, else -> ADD.
//   - CAPT: product <= {dp_Aval,dp_Bval} -> RESP.
//   - RESP: resp_valid=1 with product and id held stable. Hold while resp_ready=0.
//     resp_valid&resp_ready -> IDLE (dp_clearA=1 that cycle). No new accepts in RESP.
//   - Latency: accept at edge N -> resp_valid high from edge N+1+2*WIDTH+1 (N+18 for WIDTH=8).
//     Back-to-back throughput: 1 op per 2*WIDTH+4 cycles.
//   - At most one dp_* strobe high in any cycle; dp_S=0 outside LOAD/ADD/SHIFT.
//   - Arithmetic: two's complement; -128*-128 = +16384 fits in 16 bits.
//     x is ignored in the product.
//   - req_valid dropping before accept: no effect. Operands changing after accept: ignored.
//   - reset asserted mid-operation: aborts immediately, no response issued.
//     Datapath cleared via CLR.
//   - count is $clog2(WIDTH)+1 bits, never wraps (max WIDTH).
// STRUCTURE
//   - mult_pkg: sched_state_e {CLR,IDLE,LOAD,ADD,SHIFT,CAPT,RESP};
//     MULT_WIDTH=8; typedef mult_req_t {mcand,mplier,id}.
//   - Sub-module rr_arbiter #(N): req, advance -> one-hot grant, rotating pointer.
//   - Top: FSM, operand/product registers, counter, dp_* decode.
// TESTING
//   1 reset pulse -> dp_reset_au high exactly 1 cycle after release, then req_ready usable.
//   2 req0: 7 x -3 -> resp_product=16'hFFEB, resp_id=0, resp_valid 18 cycles after accept.
//   3 req0,req1 valid same cycle from reset -> req0 served first, then req1, no gap beyond IDLE.
//   4 both held valid for 4 ops -> ids alternate 0,1,0,1.
//   5 0x80 x 0x80 -> 16'h4000; 0xFF x 0x01 -> 16'hFFFF; 0x00 x 0x5A -> 16'h0000.
//   6 resp_ready low 10 cycles -> outputs stable, no accept; reset mid-ADD -> all outputs 0, no resp.

Source files
------------

// File: rtl/mult_scheduler_pkg.sv
// Shared types for the multiplier scheduler: FSM states, operand width and the
// latched request record.
package mult_pkg;

    localparam int MULT_WIDTH = 8;

    typedef enum logic [2:0] {
        CLR,
        IDLE,
        LOAD,
        ADD,
        SHIFT,
        CAPT,
        RESP
    } sched_state_e;

    // id is sized for the largest supported requester count (4)
    typedef struct packed {
        logic [MULT_WIDTH-1:0] mcand;
        logic [MULT_WIDTH-1:0] mplier;
        logic [1:0]            id;
    } mult_req_t;

endpackage

// File: rtl/mult_scheduler_arbiter.sv
// Round-robin arbiter: grants the first requester at or after the pointer and
// moves the pointer past the winner when the grant is consumed.
module rr_arbiter #(
    parameter int N = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic [N-1:0] grant
);
    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_d;
    logic [PW-1:0] win;
    logic [PW-1:0] idx;
    logic          found;
    int unsigned   k;

    always_comb begin
        grant = '0;
        win   = ptr_q;
        found = 1'b0;
        k     = 0;
        idx   = '0;
        for (int unsigned i = 0; i < N; i++) begin
            k = 32'(ptr_q) + i;
            if (k >= N) k = k - N;
            idx = k[PW-1:0];
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
        if (found) grant[win] = 1'b1;
        ptr_d = ptr_q;
        if (advance && found) ptr_d = (32'(win) == N - 1) ? '0 : win + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ptr_q <= '0;
        else        ptr_q <= ptr_d;
    end

endmodule

// File: rtl/mult_scheduler.sv
// Shares one signed add-shift multiplier datapath between NUM_REQ requesters:
// round-robin accept, sequence the datapath strobes, return the product.
module mult_scheduler
    import mult_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int WIDTH   = MULT_WIDTH
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*WIDTH-1:0]   req_mcand,
    input  logic [NUM_REQ*WIDTH-1:0]   req_mplier,
    output logic                       resp_valid,
    input  logic                       resp_ready,
    output logic [$clog2(NUM_REQ)-1:0] resp_id,
    output logic [2*WIDTH-1:0]         resp_product,
    output logic [WIDTH-1:0]           dp_S,
    output logic                       dp_clr_ld,
    output logic                       dp_clearA,
    output logic                       dp_add,
    output logic                       dp_sub,
    output logic                       dp_shift,
    output logic                       dp_reset_au,
    input  logic                       dp_m,
    input  logic [WIDTH-1:0]           dp_Aval,
    input  logic [WIDTH-1:0]           dp_Bval
);
    localparam int IDW = $clog2(NUM_REQ);
    localparam int CW  = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
    localparam logic [CW-1:0] ALL_BITS = CW'(WIDTH);

    sched_state_e       state_q, state_d;
    mult_req_t          req_q, req_d, sel;
    logic [CW-1:0]      count_q, count_d;
    logic [2*WIDTH-1:0] product_q, product_d;
    logic               reset_au_q, reset_au_d;
    logic [NUM_REQ-1:0] grant;
    logic               advance;

    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .clk     (clk),
        .rst_n   (reset),
        .req     (req_valid),
        .advance (advance),
        .grant   (grant)
    );

    always_comb begin
        sel = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel.mcand  = req_mcand[i*WIDTH +: WIDTH];
                sel.mplier = req_mplier[i*WIDTH +: WIDTH];
                sel.id     = 2'(i);
            end
        end
        resp_id = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (req_q.id == 2'(i)) resp_id = IDW'(i);
        end
    end

    // The datapath clear is registered so it stays low while reset is held
    // and pulses in the first cycle after CLR.
    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        count_d    = count_q;
        product_d  = product_q;
        reset_au_d = (state_q == CLR);
        advance    = 1'b0;
        req_ready  = '0;
        resp_valid = 1'b0;
        dp_S       = '0;
        dp_clr_ld  = 1'b0;
        dp_clearA  = 1'b0;
        dp_add     = 1'b0;
        dp_sub     = 1'b0;
        dp_shift   = 1'b0;
        case (state_q)
            CLR:  state_d = IDLE;
            IDLE: begin
                req_ready = grant;
                if (|grant) begin
                    advance = 1'b1;
                    req_d   = sel;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                dp_S      = req_q.mplier;
                dp_clr_ld = 1'b1;
                count_d   = '0;
                state_d   = ADD;
            end
            ADD: begin
                dp_S = req_q.mcand;
                // The multiplier's sign bit carries negative weight
                if (dp_m && count_q == LAST_BIT) dp_sub = 1'b1;
                else if (dp_m)                   dp_add = 1'b1;
                state_d = SHIFT;
            end
            SHIFT: begin
                dp_S     = req_q.mcand;
                dp_shift = 1'b1;
                count_d  = count_q + 1'b1;
                state_d  = (count_q + 1'b1 == ALL_BITS) ? CAPT : ADD;
            end
            CAPT: begin
                product_d = {dp_Aval, dp_Bval};
                state_d   = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    dp_clearA = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = CLR;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= CLR;
            req_q      <= '0;
            count_q    <= '0;
            product_q  <= '0;
            reset_au_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            count_q    <= count_d;
            product_q  <= product_d;
            reset_au_q <= reset_au_d;
        end
    end

    assign dp_reset_au  = reset_au_q;
    assign resp_product = product_q;

endmodule

// File: tb/tb_mult_scheduler.sv
// Scoreboard bench for mult_scheduler with a behavioural add-shift datapath
// responding to the dp_* strobes.
module tb_mult_scheduler;
    localparam int NR = 2;
    localparam int W  = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic [NR-1:0]     req_valid;
    logic [NR-1:0]     req_ready;
    logic [NR*W-1:0]   req_mcand;
    logic [NR*W-1:0]   req_mplier;
    logic              resp_valid;
    logic              resp_ready;
    logic [0:0]        resp_id;
    logic [2*W-1:0]    resp_product;
    logic [W-1:0]      dp_S;
    logic              dp_clr_ld, dp_clearA, dp_add, dp_sub, dp_shift, dp_reset_au;
    logic              dp_m;
    logic [W-1:0]      dp_Aval, dp_Bval;

    mult_scheduler #(.NUM_REQ(NR), .WIDTH(W)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_mcand    (req_mcand),
        .req_mplier   (req_mplier),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_id      (resp_id),
        .resp_product (resp_product),
        .dp_S         (dp_S),
        .dp_clr_ld    (dp_clr_ld),
        .dp_clearA    (dp_clearA),
        .dp_add       (dp_add),
        .dp_sub       (dp_sub),
        .dp_shift     (dp_shift),
        .dp_reset_au  (dp_reset_au),
        .dp_m         (dp_m),
        .dp_Aval      (dp_Aval),
        .dp_Bval      (dp_Bval)
    );

    always #5 clk = ~clk;

    // Datapath: x is the ninth (sign) bit of A
    logic [W-1:0] ma = '0, mb = '0;
    logic         mx = 1'b0;
    always @(posedge clk) begin
        if (dp_reset_au)    begin mx <= 1'b0; ma <= '0; mb <= '0; end
        else if (dp_clr_ld) begin mx <= 1'b0; ma <= '0; mb <= dp_S; end
        else if (dp_clearA) begin mx <= 1'b0; ma <= '0; end
        else if (dp_add)    {mx, ma} <= {mx, ma} + {dp_S[W-1], dp_S};
        else if (dp_sub)    {mx, ma} <= {mx, ma} - {dp_S[W-1], dp_S};
        else if (dp_shift)  {mx, ma, mb} <= {mx, mx, ma, mb[W-1:1]};
    end
    assign dp_m    = mb[0];
    assign dp_Aval = ma;
    assign dp_Bval = mb;

    typedef struct {
        logic [15:0] prod;
        int          id;
    } exp_t;
    exp_t sb_q[$];

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int last_acc = 0;
    bit have_acc = 1'b0;
    bit gap_chk = 1'b0;
    bit resp_prev = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    logic [5:0] strb;
    assign strb = {dp_clr_ld, dp_clearA, dp_add, dp_sub, dp_shift, dp_reset_au};

    // Monitor: protocol checks and scoreboard pops on each response handshake
    always @(negedge clk) begin
        if (reset) begin
            check("strobe_onehot", 32'($onehot0(strb)), 32'd1);
            check("ready_onehot", 32'($onehot0(req_ready)), 32'd1);
            if (|(req_ready & req_valid)) begin
                if (gap_chk && have_acc) check("accept_gap", cyc - last_acc, 32'd20);
                last_acc = cyc;
                have_acc = 1'b1;
            end
            if (resp_valid && !resp_prev && have_acc) check("latency", cyc - last_acc, 32'd19);
            if (resp_valid && resp_ready) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_resp: got product %h id %0d, none expected", resp_product, resp_id);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check("resp_product", 32'(resp_product), 32'(e.prod));
                    check("resp_id", 32'(resp_id), e.id);
                end
            end
            resp_prev = resp_valid;
        end else begin
            resp_prev = 1'b0;
        end
    end

    task automatic check_zero_outputs(input string tag);
        check({tag, "_req_ready"}, 32'(req_ready), 32'd0);
        check({tag, "_resp_valid"}, 32'(resp_valid), 32'd0);
        check({tag, "_resp_product"}, 32'(resp_product), 32'd0);
        check({tag, "_resp_id"}, 32'(resp_id), 32'd0);
        check({tag, "_strobes"}, 32'(strb), 32'd0);
        check({tag, "_dp_S"}, 32'(dp_S), 32'd0);
    endtask

    task automatic check_reset_pulse(input string tag);
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        check({tag, "_reset_au_pre"}, 32'(dp_reset_au), 32'd0);
        @(negedge clk);
        check({tag, "_reset_au_pulse"}, 32'(dp_reset_au), 32'd1);
        @(negedge clk);
        check({tag, "_reset_au_post"}, 32'(dp_reset_au), 32'd0);
    endtask

    task automatic wait_accept(input int id);
        bit ok;
        ok = 1'b0;
        for (int t = 0; t < 80 && !ok; t++) begin
            @(negedge clk);
            if (req_ready[id]) ok = 1'b1;
        end
        check("accept_seen", 32'(ok), 32'd1);
        @(posedge clk); #1;
        req_valid[id] = 1'b0;
    endtask

    task automatic issue(input int id, input logic [7:0] mc, input logic [7:0] mp,
                         input logic [15:0] ex, input bit push);
        @(posedge clk); #1;
        req_mcand[id*W +: W]  = mc;
        req_mplier[id*W +: W] = mp;
        req_valid[id]         = 1'b1;
        if (push) sb_q.push_back('{prod: ex, id: id});
        wait_accept(id);
    endtask

    task automatic drain();
        for (int t = 0; t < 200 && sb_q.size() != 0; t++) @(negedge clk);
        check("drain", 32'(sb_q.size()), 32'd0);
        repeat (2) @(negedge clk);
    endtask

    logic [7:0]  t_mc [4] = '{8'h03, 8'h0A, 8'hFB, 8'hFF};
    logic [7:0]  t_mp [4] = '{8'h04, 8'hF6, 8'h06, 8'hFF};
    logic [15:0] t_ex [4] = '{16'h000C, 16'hFF9C, 16'hFFE2, 16'h0001};
    int          t_id [4] = '{0, 1, 0, 1};

    initial begin
        int  g;
        bit  ok;
        bit  saw;
        reset      = 1'b0;
        req_valid  = '0;
        req_mcand  = '0;
        req_mplier = '0;
        resp_ready = 1'b1;

        // Reset state and the one-cycle datapath clear after release
        repeat (2) @(negedge clk);
        check_zero_outputs("reset");
        check_reset_pulse("rst1");

        // Single operation and the signed corner cases
        issue(0, 8'h07, 8'hFD, 16'hFFEB, 1'b1);
        drain();
        issue(0, 8'h80, 8'h80, 16'h4000, 1'b1);
        issue(0, 8'hFF, 8'h01, 16'hFFFF, 1'b1);
        issue(0, 8'h00, 8'h5A, 16'h0000, 1'b1);
        drain();

        // Both requesters valid from reset: alternate service, no idle gaps
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        check_reset_pulse("rst2");
        have_acc = 1'b0;
        gap_chk  = 1'b1;
        @(posedge clk); #1;
        req_mcand  = {t_mc[1], t_mc[0]};
        req_mplier = {t_mp[1], t_mp[0]};
        req_valid  = 2'b11;
        for (int n = 0; n < 4; n++) sb_q.push_back('{prod: t_ex[n], id: t_id[n]});
        for (int n = 0; n < 4; n++) begin
            ok = 1'b0;
            for (int t = 0; t < 80 && !ok; t++) begin
                @(negedge clk);
                if (|req_ready) ok = 1'b1;
            end
            check("rr_accept_seen", 32'(ok), 32'd1);
            g = req_ready[1] ? 1 : 0;
            check("rr_order", g, t_id[n]);
            @(posedge clk); #1;
            if (n + 2 < 4) begin
                req_mcand[g*W +: W]  = t_mc[n+2];
                req_mplier[g*W +: W] = t_mp[n+2];
            end else begin
                req_valid[g] = 1'b0;
            end
        end
        drain();
        gap_chk = 1'b0;

        // Consumer stall: response held, no new accept
        @(posedge clk); #1;
        resp_ready = 1'b0;
        issue(0, 8'h7F, 8'h81, 16'hC0FF, 1'b1);
        ok = 1'b0;
        for (int t = 0; t < 40 && !ok; t++) begin
            @(negedge clk);
            if (resp_valid) ok = 1'b1;
        end
        check("stall_valid_seen", 32'(ok), 32'd1);
        @(posedge clk); #1;
        req_mcand[1*W +: W]  = 8'h02;
        req_mplier[1*W +: W] = 8'h03;
        req_valid[1]         = 1'b1;
        sb_q.push_back('{prod: 16'h0006, id: 1});
        for (int t = 0; t < 10; t++) begin
            @(negedge clk);
            check("stall_valid", 32'(resp_valid), 32'd1);
            check("stall_product", 32'(resp_product), 32'h0000C0FF);
            check("stall_id", 32'(resp_id), 32'd0);
            check("stall_no_accept", 32'(req_ready), 32'd0);
        end
        @(posedge clk); #1;
        resp_ready = 1'b1;
        wait_accept(1);
        drain();

        // Reset during ADD aborts the operation with no response
        issue(0, 8'h05, 8'h05, 16'h0000, 1'b0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check_zero_outputs("abort");
        check_reset_pulse("rst3");
        saw = 1'b0;
        for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            saw = saw | resp_valid;
        end
        check("abort_no_resp", 32'(saw), 32'd0);
        issue(0, 8'h12, 8'h34, 16'h03A8, 1'b1);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
